triggered_wave_writer: RTL and testbench
========================================

TRIGGERED_WAVE_WRITER -- requirements
Module: triggered_wave_writer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Ports (name  direction  width  meaning):
  clk  in  1  system clock
  reset  in  1  async active-high reset
  new_sample_ready  in  1  one-cycle strobe, new_sample_in valid
  new_sample_in  in  16  signed two's-complement audio sample
  wave_display_idle  in  1  high while display is not reading RAM (vertical blank)
  write_address  out  9  RAM write address {half, index[7:0]}
  write_enable  out  1  one-cycle RAM write strobe
  write_sample  out  8  unsigned offset-binary sample for display
  read_index  out  1  RAM half the display SHALL read; writer uses ~read_index

Function
REQ-003 The block SHALL be a writer for a 512-entry RAM split into two 256-entry halves, as a ping-pong buffer.
REQ-004 FSM states: ARMED, ACTIVE, WAIT.
REQ-005 The block SHALL hold prev_neg, which is new_sample_in[15] of the last accepted sample and is updated on every new_sample_ready in every state.
REQ-006 Trigger: in ARMED, a new_sample_ready with prev_neg=1 and new_sample_in[15]=0 SHALL be a rising zero crossing.
REQ-007 On trigger the FSM SHALL go to ACTIVE, and the trigger sample SHALL be written at index 0.
REQ-008 In ACTIVE, each new_sample_ready SHALL write one sample at index count and then increment count.
REQ-009 When the write at index 255 is issued, the FSM SHALL go to WAIT and count SHALL wrap to 0.
REQ-010 Write data SHALL be write_sample = {~s[15], s[14:8]}, where s is new_sample_in; this is the top byte converted to offset binary (0x8000 gives 0x00, 0x0000 gives 0x80, 0x7FFF gives 0xFF).
REQ-011 write_address SHALL be {~read_index, count}.
REQ-012 write_enable, write_address and write_sample SHALL be registered and SHALL appear exactly 1 cycle after the accepting new_sample_ready.
REQ-013 write_enable SHALL be high for exactly 1 cycle per accepted sample.
REQ-014 write_enable SHALL never be asserted in ARMED except for the trigger sample, and SHALL never be asserted in WAIT.
REQ-015 In WAIT, samples SHALL be discarded (only prev_neg updates).
REQ-016 In WAIT, the first cycle with wave_display_idle=1 SHALL toggle read_index and return the FSM to ARMED.
REQ-017 If wave_display_idle is already high on entry to WAIT, the toggle SHALL occur on the next cycle.
REQ-018 read_index SHALL change only on the WAIT to ARMED transition, so the display never sees a half-written buffer.
REQ-019 A new_sample_ready in the same cycle as the WAIT to ARMED transition SHALL update prev_neg only and SHALL NOT trigger.
REQ-020 wave_display_idle SHALL have no effect in ARMED or ACTIVE.

Reset
REQ-021 On reset the state SHALL be ARMED, with count=0, prev_neg=0, read_index=0, write_enable=0, write_address=0 and write_sample=0.
REQ-022 Because prev_neg resets to 0, the first sample after reset SHALL NOT trigger.
REQ-023 Reset asserted during ACTIVE or WAIT SHALL abandon the partial capture; the RAM contents are not cleared.

Configuration
REQ-024 Macro TRIGGER_TIMEOUT_EN SHALL compile in the auto-trigger feature.
REQ-025 When defined, a 12-bit counter SHALL count samples accepted in ARMED without a trigger.
REQ-026 When that counter reaches 4095 and another sample arrives, that sample SHALL force a trigger exactly as REQ-007.
REQ-027 The timeout counter SHALL clear on entry to ARMED, on any trigger, and on reset.
REQ-028 When TRIGGER_TIMEOUT_EN is undefined, the block SHALL wait in ARMED indefinitely and no timeout logic SHALL exist.

Verification
REQ-029 Sample sequence 0xFF00, 0x0100, then 255 further samples -> 256 write strobes at addresses 0x100..0x1FF, first write_sample=0x81, read_index still 0.
REQ-030 After REQ-029, with wave_display_idle held low for 100 cycles and then raised -> read_index goes to 1 one cycle after idle rises, and the next capture writes at addresses 0x000..0x0FF.
REQ-031 Constant +0x1000 samples (no crossing) -> no write_enable when the macro is undefined; when TRIGGER_TIMEOUT_EN is defined, the 4097th sample writes at address 0x100 with write_sample 0x90.
REQ-032 Reset pulsed after 10 ACTIVE writes -> all outputs 0 and state ARMED; the next crossing restarts at index 0 of half 1.
REQ-033 new_sample_ready held every cycle in ACTIVE -> one write per cycle, address increments by 1 per cycle with 1-cycle latency, and count wraps 255 to 0 into WAIT.
REQ-034 Samples 0x8000, 0x0000 and 0x7FFF written -> write_sample values 0x00, 0x80 and 0xFF.

Source files
------------

// File: rtl/triggered_wave_writer.sv
// Ping-pong RAM writer: captures 256 samples from a rising zero crossing into the half not shown by the display.
// Optional auto-trigger after a long run without a crossing is compiled in with `define TRIGGER_TIMEOUT_EN.
module triggered_wave_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    input  logic        wave_display_idle,
    output logic [8:0]  write_address,
    output logic        write_enable,
    output logic [7:0]  write_sample,
    output logic        read_index
);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  count_reg, count_next;
    logic        prev_neg_reg;
    logic        read_index_reg, read_index_next;
    logic        write_enable_reg, write_enable_next;
    logic [8:0]  write_address_reg, write_address_next;
    logic [7:0]  write_sample_reg, write_sample_next;

    logic        rising_cross;
    logic        trigger;
    logic [7:0]  offset_sample;
    logic        unused_low_bits;

    // Only the top byte reaches the display; flipping the sign bit gives offset binary.
    assign offset_sample   = {~new_sample_in[15], new_sample_in[14:8]};
    assign rising_cross    = prev_neg_reg & ~new_sample_in[15];
    assign unused_low_bits = ^new_sample_in[7:0];

`ifdef TRIGGER_TIMEOUT_EN
    logic [11:0] timeout_reg, timeout_next;
    logic        prev_valid_reg;
    logic        timeout_hit;

    assign timeout_hit = (timeout_reg == 12'hFFF);
    assign trigger     = new_sample_ready & (rising_cross | timeout_hit);

    // A sample only counts as a missed trigger once there is a previous sample to compare against.
    always_comb begin
        timeout_next = timeout_reg;
        if ((state_reg != ARMED) || trigger) begin
            timeout_next = 12'd0;
        end else if (new_sample_ready && prev_valid_reg) begin
            timeout_next = timeout_reg + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_reg    <= 12'd0;
            prev_valid_reg <= 1'b0;
        end else begin
            timeout_reg <= timeout_next;
            if (new_sample_ready) begin
                prev_valid_reg <= 1'b1;
            end
        end
    end
`else
    assign trigger = new_sample_ready & rising_cross;
`endif

    always_comb begin
        state_next         = state_reg;
        count_next         = count_reg;
        read_index_next    = read_index_reg;
        write_enable_next  = 1'b0;
        write_address_next = write_address_reg;
        write_sample_next  = write_sample_reg;

        case (state_reg)
            ARMED: begin
                if (trigger) begin
                    write_enable_next  = 1'b1;
                    write_address_next = {~read_index_reg, 8'd0};
                    write_sample_next  = offset_sample;
                    count_next         = 8'd1;
                    state_next         = ACTIVE;
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    write_enable_next  = 1'b1;
                    write_address_next = {~read_index_reg, count_reg};
                    write_sample_next  = offset_sample;
                    count_next         = count_reg + 8'd1;
                    if (count_reg == 8'hFF) begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // Swapping halves only here keeps the display off a partly written buffer.
                if (wave_display_idle) begin
                    read_index_next = ~read_index_reg;
                    state_next      = ARMED;
                end
            end
            default: begin
                state_next = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= ARMED;
            count_reg         <= 8'd0;
            prev_neg_reg      <= 1'b0;
            read_index_reg    <= 1'b0;
            write_enable_reg  <= 1'b0;
            write_address_reg <= 9'd0;
            write_sample_reg  <= 8'd0;
        end else begin
            state_reg         <= state_next;
            count_reg         <= count_next;
            read_index_reg    <= read_index_next;
            write_enable_reg  <= write_enable_next;
            write_address_reg <= write_address_next;
            write_sample_reg  <= write_sample_next;
            if (new_sample_ready) begin
                prev_neg_reg <= new_sample_in[15];
            end
        end
    end

    assign write_enable  = write_enable_reg;
    assign write_address = write_address_reg;
    assign write_sample  = write_sample_reg;
    assign read_index    = read_index_reg;

endmodule

// File: tb/tb_triggered_wave_writer.sv
// Scoreboard bench for triggered_wave_writer: expected RAM writes are queued as samples are driven.
module tb_triggered_wave_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    triggered_wave_writer dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    always #5 clk = ~clk;

    // Each write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && write_enable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", write_address, write_sample);
            end else begin
                mon_e = exp_q.pop_front();
                if ({write_address, write_sample} !== mon_e) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             write_address, write_sample, mon_e.addr, mon_e.data);
                end else begin
                    $display("write addr=%h data=%h ok", write_address, write_sample);
                end
            end
        end
    end

    function automatic logic [7:0] offbin(input logic [15:0] s);
        return {~s[15], s[14:8]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] s);
        new_sample_ready = 1'b1;
        new_sample_in    = s;
        tick(1);
        new_sample_ready = 1'b0;
    endtask

    task automatic send_w(input logic [15:0] s, input logic [8:0] addr);
        exp_q.push_back('{addr: addr, data: offbin(s)});
        send(s);
    endtask

    task automatic capture_rest(input logic [8:0] base, input int start, input bit gaps);
        logic [15:0] s;
        for (int i = start; i < 256; i++) begin
            s = 16'($urandom);
            send_w(s, base + 9'(i));
            if (gaps) tick($urandom_range(0, 2));
        end
    endtask

    task automatic check_drained(input string name);
        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_rd(input string name, input logic req);
        checks++;
        if (read_index !== req) begin
            errors++;
            $display("FAIL %s: got read_index=%b, required %b", name, read_index, req);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({write_enable, write_address, write_sample, read_index} !== 19'd0) begin
            errors++;
            $display("FAIL %s: got we=%b addr=%h data=%h rd=%b, required all 0",
                     name, write_enable, write_address, write_sample, read_index);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        new_sample_ready = 1'b0;
        new_sample_in = 16'h0000;
        wave_display_idle = 1'b0;
        tick(3);
        check_outputs_zero("reset_state");
        reset = 1'b0;
        tick(1);
        check_outputs_zero("after_reset");
    endtask

    task automatic test_no_trigger();
`ifdef TRIGGER_TIMEOUT_EN
        for (int i = 0; i < 4096; i++) send(16'h1000);
        exp_q.push_back('{addr: 9'h100, data: 8'h90});
        send(16'h1000);
`else
        for (int i = 0; i < 4200; i++) send(16'h1000);
`endif
        check_drained("no_trigger");
        check_rd("no_trigger_rd", 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_capture();
        send(16'hFF00);
        exp_q.push_back('{addr: 9'h100, data: 8'h81});
        send(16'h0100);
        capture_rest(9'h100, 1, 1'b1);
        check_drained("capture");
        check_rd("capture_rd", 1'b0);
        // Crossing while waiting must be discarded.
        send(16'h8000);
        send(16'h0100);
        check_drained("wait_discard");
    endtask

    task automatic test_swap();
        tick(100);
        check_rd("swap_idle_low", 1'b0);
        send(16'h8000);
        wave_display_idle = 1'b1;
        new_sample_ready  = 1'b1;
        new_sample_in     = 16'h0100;
        check_rd("swap_before_edge", 1'b0);
        tick(1);
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
        check_rd("swap_toggled", 1'b1);
        check_drained("swap_no_trigger");
        send(16'hC000);
        exp_q.push_back('{addr: 9'h000, data: 8'hA0});
        send(16'h2000);
        capture_rest(9'h000, 1, 1'b1);
        check_drained("capture_half0");
        check_rd("capture_half0_rd", 1'b1);
    endtask

    task automatic test_back_to_back();
        wave_display_idle = 1'b1;
        tick(1);
        check_rd("b2b_swap", 1'b0);
        send(16'h8000);
        exp_q.push_back('{addr: 9'h100, data: 8'h81});
        send(16'h0100);
        capture_rest(9'h100, 1, 1'b0);
        check_rd("b2b_entry_wait", 1'b0);
        tick(1);
        check_rd("b2b_idle_on_entry", 1'b1);
        wave_display_idle = 1'b0;
        check_drained("b2b");
    endtask

    task automatic test_reset_mid();
        send(16'h8000);
        exp_q.push_back('{addr: 9'h000, data: 8'h81});
        send(16'h0100);
        for (int i = 1; i < 10; i++) send_w(16'($urandom), 9'(i));
        tick(1);
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_mid");
        tick(1);
        reset = 1'b0;
        check_drained("reset_mid");
        check_outputs_zero("reset_mid_after");
        send(16'h0100);
        send(16'h8000);
        exp_q.push_back('{addr: 9'h100, data: 8'h81});
        send(16'h0100);
    endtask

    task automatic test_conversion();
        exp_q.push_back('{addr: 9'h101, data: 8'h00});
        send(16'h8000);
        exp_q.push_back('{addr: 9'h102, data: 8'h80});
        send(16'h0000);
        exp_q.push_back('{addr: 9'h103, data: 8'hFF});
        send(16'h7FFF);
        capture_rest(9'h100, 4, 1'b0);
        check_drained("conversion");
        check_rd("conversion_rd", 1'b0);
    endtask

    initial begin
        test_reset();
        test_no_trigger();
        test_capture();
        test_swap();
        test_back_to_back();
        test_reset_mid();
        test_conversion();
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
